ddr_gearbox_5to20: RTL and testbench
====================================

# ddr_gearbox_5to20

Packs the 5-sample-per-clock, 14-bit stream into the 2-lane × 10-slot parallel frame consumed by the DDR output interface. It sits directly upstream of the OSERDES interface stage. It accumulates four input beats into one 20-sample frame and double-buffers it. It presents each frame on a free-running 4-cycle phase boundary, so the divided serializer clock (clk/4, phase-aligned via `out_phase`) samples a stable word. Overrun and underrun are detected and flagged.

## Interface
- `WIDTH`, 14: bits per sample.
- `IN_WORDS`, 5: samples per input beat.
- `LANES`, 2: output serializer lanes.
- `SER`, 10: slots per lane per frame.
- Derived: `BEATS = LANES*SER/IN_WORDS` = 4. `LANES*SER` must be divisible by `IN_WORDS`; elaboration error otherwise. `BEATS` must be a power of two.

- `clk` in 1: sole clock, same clock the sample data arrives on.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in IN_WORDS×WIDTH: one beat; index 0 is earliest in time.
- `in_valid` in 1: beat qualifier.
- `sync` in 1: frame alignment; discards any partial frame.
- `clear_err` in 1: clears sticky error flags.
- `out_data` out LANES×SER×WIDTH: frame as [lane][slot][bit]; slot 0 is serialized first.
- `out_phase` out log2(BEATS): free-running phase counter; divided-clock rising edge aligns to phase 0.
- `out_load` out 1: high for the cycle in which `out_phase`==0.
- `out_valid` out 1: current `out_data` is a real frame, not idle fill.
- `overrun` out 1: sticky; a completed frame overwrote an undrained pending frame.
- `underrun` out 1: sticky; a wrap found no pending frame after streaming started.

## Operation
- Sample index within a frame: k = beat*IN_WORDS + i, where beat is 0..3 and i is 0..4. Sample k goes to lane k%LANES, slot k/LANES.
  - Lane 0 carries even samples; lane 1 carries odd samples.
- **Assembly buffer and beat counter (0..BEATS-1).**
  - Each `in_valid` beat is written at the current beat position, then the counter increments.
  - On the beat where the counter is at BEATS-1, the completed frame (including that beat) is copied to the pending buffer, `pending_full` is set, and the counter wraps to 0.
  - `in_valid`=0 holds the counter; gaps inside a frame are legal.
- **sync.**
  - `sync`=1 with `in_valid`=0: counter cleared to 0 and the partial frame discarded.
  - `sync`=1 with `in_valid`=1: the beat is taken as beat 0 and the counter becomes 1.
  - `sync` never affects `pending_full` or the output.
- **Phase counter.** Increments every cycle and wraps from BEATS-1 to 0. It is unaffected by `sync` and `in_valid`.
- **Wrap edge** (the edge at which `out_phase` goes from BEATS-1 to 0):
  - If `pending_full`: `out_data` ← pending, `out_valid`←1, and `pending_full` cleared.
  - Else: `out_data` ← all zeros and `out_valid`←0. If `running`, `underrun`←1.
- `running` is set by the first frame completion after reset and is cleared only by reset.
- Frame completes while `pending_full`, on a non-wrap edge: pending is overwritten with the new frame and `overrun`←1.
- Frame completes on the wrap edge itself: the old pending frame drains to `out_data` and the new frame enters pending (`pending_full` stays 1). No overrun.
- A frame that completes on the wrap edge with pending empty does not bypass to `out_data`; it drains at the next wrap.
- `clear_err`=1 clears `overrun`/`underrun` at the next edge. If a new error occurs in the same cycle, setting has priority.

## Timing
- Reset values (asynchronous):
  - `out_data`=0, `out_valid`=0, `out_phase`=0, `out_load`=0, `overrun`=0, `underrun`=0.
  - Beat counter 0, `pending_full`=0, `running`=0.
- `out_load` is registered: it is 1 exactly in cycles where `out_phase`==0, starting with the first wrap after reset (4 cycles after release).
- All outputs are registered; `out_data` changes only on wrap edges and is stable for BEATS cycles.
- Latency from the completing beat's sampling edge E to `out_data` update: the next wrap edge strictly after E, i.e. 1 to BEATS cycles. This assumes pending was empty or drains at that wrap.
- Sustained input of `in_valid`=1 every cycle gives exactly one frame per wrap, with no overrun or underrun in steady state.
- Reset asserted mid-frame: partial and pending data are lost and all state returns to reset values immediately.

## Test plan
- **Continuous ramp.** After reset, `in_valid`=1 every cycle with sample k = k (values 0,1,2,…). Required: the first `out_valid` frame has lane0 slots = 0,2,…,18 and lane1 slots = 1,3,…,19. Subsequent frames increase by 20. No error flags.
- **Gapped input.** Beats spaced one idle cycle apart. Required: every wrap with no pending frame gives `out_valid`=0, zero data, and `underrun`=1 (sticky). Frame contents remain correct.
- **Overrun.** Pulse the ready path so two frames complete within one phase period, at non-wrap edges. Required: `overrun`=1, and the second frame (not the first) appears at the next wrap.
- **sync mid-frame.** Send 2 beats, then `sync`+valid with value 100..104, then 3 more beats. Required: the output frame starts with lane0 slot0=100 and lane1 slot0=101. The earlier beats never appear.
- **Wrap-edge completion and clear.** Align the 4th beat to the wrap edge while pending is full. Required: the old frame is output, the new frame is output at the following wrap, and `overrun`=0. Then assert `clear_err` with no new error: both flags go to 0 on the next cycle.
- **Async reset mid-stream.** Assert `rst_n`=0 between clock edges. Required: all outputs go to 0 immediately. After release, `out_load` first pulses 4 cycles later.

Source files
------------

// File: rtl/ddr_gearbox_5to20.sv
// Packs 5-sample beats into 2-lane x 10-slot frames, double-buffered, presented on a 4-cycle phase boundary.
// Latency: completing beat to out_data is 1..BEATS cycles (next phase wrap strictly after the beat's edge).
// Backpressure: none; a completion onto an undrained frame overwrites it (overrun), a wrap with nothing pending emits idle fill (underrun).
module ddr_gearbox_5to20 #(
    parameter int WIDTH    = 14,
    parameter int IN_WORDS = 5,
    parameter int LANES    = 2,
    parameter int SER      = 10,
    localparam int BEATS   = LANES * SER / IN_WORDS,
    localparam int PW      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IN_WORDS*WIDTH-1:0]    data_in,
    input  logic                         in_valid,
    input  logic                         sync,
    input  logic                         clear_err,
    output logic [LANES*SER*WIDTH-1:0]   out_data,
    output logic [PW-1:0]                out_phase,
    output logic                         out_load,
    output logic                         out_valid,
    output logic                         overrun,
    output logic                         underrun
);

    localparam int FW = LANES * SER * WIDTH;

    // Frame geometry must tile exactly into whole beats, and the phase counter wraps naturally.
    if ((LANES * SER) % IN_WORDS != 0) begin : g_bad_ratio
        $error("LANES*SER must be divisible by IN_WORDS");
    end
    if ((BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
        $error("BEATS must be a power of two");
    end

    // Bit offset of frame sample k: even samples on lane 0, odd on lane 1, slot = k/LANES.
    function automatic int slot_base(input int k);
        return ((k % LANES) * SER + k / LANES) * WIDTH;
    endfunction

    logic [PW-1:0] beat_cnt;
    logic [PW-1:0] beat_pos;
    logic [FW-1:0] asm_buf;
    logic [FW-1:0] asm_next;
    logic [FW-1:0] pending;
    logic          pending_full;
    logic          running;
    logic          wrap;
    logic          complete;
    logic          set_ovr;
    logic          set_und;

    // Beat placement: sync forces the incoming beat to position 0; merged frame feeds both buffers.
    always_comb begin
        beat_pos = sync ? '0 : beat_cnt;
        complete = in_valid && (beat_pos == PW'(BEATS - 1));
        wrap     = (out_phase == PW'(BEATS - 1));
        set_ovr  = complete && pending_full && !wrap;
        set_und  = wrap && !pending_full && running;
        asm_next = asm_buf;
        if (in_valid) begin
            for (int b = 0; b < BEATS; b++) begin
                for (int i = 0; i < IN_WORDS; i++) begin
                    if (beat_pos == PW'(b)) begin
                        asm_next[slot_base(b * IN_WORDS + i) +: WIDTH] = data_in[i * WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Assembly buffer and beat counter; idle cycles hold, a bare sync discards the partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_buf  <= '0;
            beat_cnt <= '0;
        end else if (in_valid) begin
            asm_buf  <= asm_next;
            beat_cnt <= complete ? '0 : beat_pos + PW'(1);
        end else if (sync) begin
            beat_cnt <= '0;
        end
    end

    // Pending buffer and output register; drain only on the wrap edge, never bypass assembly to output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            pending_full <= 1'b0;
            running      <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
        end else begin
            if (wrap) begin
                out_data  <= pending_full ? pending : '0;
                out_valid <= pending_full;
            end
            if (complete) begin
                pending      <= asm_next;
                pending_full <= 1'b1;
                running      <= 1'b1;
            end else if (wrap) begin
                pending_full <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle wins over clear_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (set_und) begin
                underrun <= 1'b1;
            end else if (clear_err) begin
                underrun <= 1'b0;
            end
        end
    end

    // Free-running phase; out_load marks the cycle after each wrap, i.e. phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_phase <= '0;
            out_load  <= 1'b0;
        end else begin
            out_phase <= out_phase + PW'(1);
            out_load  <= wrap;
        end
    end

endmodule

// File: tb/tb_ddr_gearbox_5to20.sv
// Randomized bench for ddr_gearbox_5to20 with a sample-queue reference model and scoreboard.
// Stimulus is applied on falling edges; a monitor compares #1 after each rising edge.
// Expected per-cycle status and per-wrap frames are queued by the model and popped by the monitor.
module tb_ddr_gearbox_5to20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [69:0]  data_in;
    logic         in_valid;
    logic         sync;
    logic         clear_err;
    logic [279:0] out_data;
    logic [1:0]   out_phase;
    logic         out_load;
    logic         out_valid;
    logic         overrun;
    logic         underrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           vld;
        logic [279:0] dat;
    } frm_t;

    typedef struct {
        int ph;
        bit ld;
        bit ov;
        bit un;
    } st_t;

    frm_t fq[$];
    st_t  sq[$];

    // Reference model state: samples of the frame being collected, the waiting frame, flags.
    int m_ph;
    int m_asm[$];
    int m_pend[20];
    bit m_pf;
    bit m_run;
    bit m_ov;
    bit m_un;

    ddr_gearbox_5to20 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .sync      (sync),
        .clear_err (clear_err),
        .out_data  (out_data),
        .out_phase (out_phase),
        .out_load  (out_load),
        .out_valid (out_valid),
        .overrun   (overrun),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [279:0] act, input logic [279:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame layout from sample order: sample k lands on lane k%2, slot k/2.
    function automatic logic [279:0] pack(input int f[20]);
        logic [279:0] r;
        r = '0;
        for (int k = 0; k < 20; k++) begin
            r[((k % 2) * 10 + k / 2) * 14 +: 14] = 14'(f[k]);
        end
        return r;
    endfunction

    function automatic logic [69:0] ramp(input int base);
        logic [69:0] r;
        for (int i = 0; i < 5; i++) r[i * 14 +: 14] = 14'(base + i);
        return r;
    endfunction

    function automatic logic [69:0] rnd();
        logic [69:0] r;
        for (int i = 0; i < 5; i++) r[i * 14 +: 14] = 14'($urandom_range(0, 16383));
        return r;
    endfunction

    function automatic void model_reset();
        m_ph  = 0;
        m_asm.delete();
        m_pf  = 0;
        m_run = 0;
        m_ov  = 0;
        m_un  = 0;
        fq.delete();
        sq.delete();
    endfunction

    // Effect of one rising edge on the behavioural model, queuing what the DUT should show after it.
    function automatic void model(input bit v, input bit s, input bit c, input logic [69:0] d);
        bit   comp;
        bit   wrap;
        bit   so;
        bit   su;
        int   nf[20];
        frm_t fr;
        st_t  st;
        comp = 0;
        if (s) m_asm.delete();
        if (v) for (int i = 0; i < 5; i++) m_asm.push_back(int'(d[i * 14 +: 14]));
        if (m_asm.size() == 20) begin
            comp = 1;
            for (int k = 0; k < 20; k++) nf[k] = m_asm[k];
            m_asm.delete();
        end
        wrap = (m_ph == 3);
        so   = comp && m_pf && !wrap;
        su   = wrap && !m_pf && m_run;
        if (wrap) begin
            fr.vld = m_pf;
            fr.dat = m_pf ? pack(m_pend) : '0;
            fq.push_back(fr);
        end
        if (comp) begin
            m_pend = nf;
            m_pf   = 1;
            m_run  = 1;
        end else if (wrap) begin
            m_pf = 0;
        end
        m_ov  = so ? 1'b1 : (c ? 1'b0 : m_ov);
        m_un  = su ? 1'b1 : (c ? 1'b0 : m_un);
        m_ph  = (m_ph + 1) % 4;
        st.ph = m_ph;
        st.ld = wrap;
        st.ov = m_ov;
        st.un = m_un;
        sq.push_back(st);
    endfunction

    task automatic step(input bit v, input bit s, input bit c, input logic [69:0] d);
        @(negedge clk);
        in_valid  = v;
        sync      = s;
        clear_err = c;
        data_in   = d;
        model(v, s, c, d);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_out_valid"}, out_valid, '0);
        chk({tag, "_out_phase"}, out_phase, '0);
        chk({tag, "_out_load"}, out_load, '0);
        chk({tag, "_overrun"}, overrun, '0);
        chk({tag, "_underrun"}, underrun, '0);
    endtask

    // Monitor: per-cycle status every edge; a frame is popped whenever the DUT presents out_load.
    initial begin
        st_t  st;
        frm_t fr;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                st = sq.pop_front();
                chk("out_phase", out_phase, st.ph);
                chk("out_load", out_load, st.ld);
                chk("overrun", overrun, st.ov);
                chk("underrun", underrun, st.un);
                if (out_load) begin
                    if (fq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected actual=out_load required=no_frame");
                    end else begin
                        fr = fq.pop_front();
                        chk("out_valid", out_valid, fr.vld);
                        chk("out_data", out_data, fr.dat);
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sync      = 1'b0;
        clear_err = 1'b0;
        data_in   = '0;
        model_reset();
        #12;
        chk_reset("reset");
        #5 rst_n = 1'b1;

        // Continuous ramp: sample k = k, ten frames back to back.
        for (int n = 0; n < 40; n++) step(1'b1, 1'b0, 1'b0, ramp(n * 5));

        // Gapped input: one idle cycle between beats, underrun at empty wraps.
        for (int n = 0; n < 32; n++) step(n % 2 == 0, 1'b0, 1'b0, rnd());

        // sync mid-frame: two stale beats, then a realigned frame starting at 100.
        step(1'b1, 1'b0, 1'b0, rnd());
        step(1'b1, 1'b0, 1'b0, rnd());
        step(1'b1, 1'b1, 1'b0, ramp(100));
        for (int n = 1; n < 4; n++) step(1'b1, 1'b0, 1'b0, ramp(100 + n * 5));
        for (int n = 0; n < 8; n++) step(1'b0, 1'b0, 1'b0, '0);

        // clear_err on a non-wrap edge with no new error.
        while (m_ph != 0) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("overrun_after_clear", overrun, '0);
        chk("underrun_after_clear", underrun, '0);

        // Random mix of valid, sync and clear_err.
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0, rnd());
        end

        // Async reset between edges, mid-stream.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        in_valid  = 1'b0;
        sync      = 1'b0;
        clear_err = 1'b0;

        for (int n = 0; n < 24; n++) step(1'b1, 1'b0, 1'b0, ramp(1000 + n * 5));
        for (int n = 0; n < 8; n++) step(1'b0, 1'b0, 1'b0, '0);

        @(posedge clk);
        #2;
        chk("frames_left", 280'(fq.size()), '0);
        chk("status_left", 280'(sq.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
